load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory stage that sits directly downstream of the execute stage and consumes its ALU result.
- For IS_LOAD/IS_STORE, the ALU result is the effective address. The block issues one data-memory request via a valid/ready handshake, waits for load data, then aligns and sign/zero-extends it.
- All other instruction types pass the ALU result through to writeback with one cycle of latency.
- in_ready stalls upstream while a memory access is in flight.

Parameters:
- WIDTH, 32, data/address width (the byte-lane logic is defined for 32 only).
- REG_WIDTH, 5, destination register index width.
- INSTR_TYPE_WIDTH, 8, instruction-type code width (shared IS_* encoding).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  reset, synchronous, active-high.
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  block accepts; high only in IDLE.
- instr_type  in  INSTR_TYPE_WIDTH  decoded type (IS_LOAD, IS_STORE, others).
- funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- alu_result  in  WIDTH  execute result / effective address.
- rs2  in  WIDTH  store data.
- rd  in  REG_WIDTH  destination register.
- rd_we  in  1  instruction writes rd.
- mem_req_valid  out  1  memory request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_req_we  out  1  1 = store.
- mem_req_addr  out  WIDTH  word-aligned address {addr[31:2],2'b00}.
- mem_req_wdata  out  WIDTH  lane-replicated store data.
- mem_req_be  out  4  byte enables.
- mem_rsp_valid  in  1  load data valid.
- mem_rsp_rdata  in  WIDTH  load data word.
- out_valid  out  1  one-cycle pulse: result to writeback.
- out_rd  out  REG_WIDTH  destination register.
- out_data  out  WIDTH  writeback data.
- out_we  out  1  register write enable.
- out_fault  out  1  misaligned or illegal funct3; no memory access made.

Behaviour:
- Reset: state IDLE; mem_req_valid, out_valid, out_we and out_fault = 0; data/addr outputs = 0. in_ready = 1 from the first cycle after reset.
- Reset mid-operation: next edge returns to IDLE and drops mem_req_valid. A mem_rsp_valid seen in IDLE is ignored.
- Handshake: an instruction is accepted on in_valid && in_ready. Operands are registered at acceptance; inputs are don't-care afterwards.
- States: IDLE, REQ, WAIT_RSP.
- IDLE, non-memory op accepted at edge N: out_valid=1 in cycle N+1 with out_data=alu_result, out_rd=rd, out_we=rd_we. Stays in IDLE, so back-to-back throughput is 1 per cycle.
- IDLE, load/store accepted:
  - Fault if H with addr[0]=1, if W with addr[1:0]!=0, or if funct3 is 011/110/111 (all of these on stores too).
  - Fault: next cycle out_valid=1, out_fault=1, out_we=0, no memory request.
  - Otherwise go to REQ.
- REQ: mem_req_valid held high, with all req fields stable, until mem_req_ready.
  - Store handshake at edge M: out_valid=1, out_we=0 in cycle M+1; go to IDLE.
  - Load handshake: go to WAIT_RSP.
- WAIT_RSP: mem_rsp_valid at edge K gives out_valid=1 in cycle K+1 with out_we=rd_we and aligned data; go to IDLE.
  - Memory guarantees the response arrives no earlier than the cycle after the request handshake.
- Store lanes:
  - B: be=4'b0001<<addr[1:0], wdata={4{rs2[7:0]}}.
  - H: be=4'b0011<<addr[1:0], wdata={2{rs2[15:0]}}.
  - W: be=4'b1111, wdata=rs2.
- Load data: shifted = rdata >> (8*addr[1:0]).
  - B: sign-extend shifted[7:0]. BU: zero-extend shifted[7:0].
  - H: sign-extend shifted[15:0]. HU: zero-extend shifted[15:0].
  - W: rdata.
- out_valid is a single-cycle pulse; writeback never backpressures.
- in_ready = (state==IDLE) && !reset.

Decomposition:
- Shared package: IS_* type codes (existing shared defines); funct3 size constants F3_B/H/W/BU/HU; state encoding localparams.
- Sub-module lsu_align (combinational): store be/wdata generation, load shift/extend, fault detection.
- FSM and registers stay in load_store_unit.

Test Plan:
- ADDI path: alu_result=0x00000005, rd=3, rd_we=1 accepted → next cycle out_valid=1, out_data=0x5, out_rd=3, out_we=1; back-to-back second op accepted in the following cycle.
- SB addr=0x00001003, rs2=0xAABBCCDD, mem_req_ready delayed 2 cycles → mem_req_addr=0x1000, be=4'b1000, wdata=0xDDDDDDDD held stable; out_valid cycle after handshake, out_we=0; in_ready=0 throughout.
- LB/LBU addr=0x2001, rdata=0x123480FF → LB out_data=0xFFFFFF80, LBU out_data=0x00000080; LH addr=0x2002, rdata=0x80010000 → 0xFFFF8001.
- LW addr=0x2002 → no mem_req_valid, next cycle out_valid=1, out_fault=1, out_we=0; funct3=011 load gives the same fault.
- Load with 3-cycle response delay, reset asserted in WAIT_RSP → next cycle IDLE, in_ready=1, mem_req_valid=0; late mem_rsp_valid produces no out_valid.
- SW addr=0x3000, rs2=0xCAFEBABE with mem_req_ready=1 immediately → be=4'b1111, wdata=0xCAFEBABE, out_valid two cycles after acceptance.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the memory stage: instruction-type codes, access-size
// encodings and the load/store FSM state type.
package load_store_unit_pkg;

    localparam logic [7:0] IS_ALU    = 8'h01;
    localparam logic [7:0] IS_LOAD   = 8'h02;
    localparam logic [7:0] IS_STORE  = 8'h03;
    localparam logic [7:0] IS_BRANCH = 8'h04;
    localparam logic [7:0] IS_JUMP   = 8'h05;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store enables/replication, load shift and
// sign/zero extension, and misalignment / illegal-size detection.
module lsu_align
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       funct3,
    input  logic [1:0]       addr_lo,
    input  logic [WIDTH-1:0] store_data,
    input  logic [WIDTH-1:0] load_word,
    output logic [3:0]       be,
    output logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] load_data,
    output logic             fault
);

    logic [WIDTH-1:0]  shifted;
    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        shifted   = load_word >> {addr_lo, 3'b000};
        byte_s    = shifted[7:0];
        half_s    = shifted[15:0];
        be        = 4'b0000;
        wdata     = store_data;
        load_data = load_word;
        fault     = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
                if (funct3 == F3_B) load_data = WIDTH'(byte_s);
                else                load_data = WIDTH'(shifted[7:0]);
            end
            F3_H, F3_HU: begin
                be    = 4'b0011 << addr_lo;
                wdata = {2{store_data[15:0]}};
                fault = addr_lo[0];
                if (funct3 == F3_H) load_data = WIDTH'(half_s);
                else                load_data = WIDTH'(shifted[15:0]);
            end
            F3_W: begin
                be    = 4'b1111;
                fault = (addr_lo != 2'b00);
            end
            default: fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: passes ALU results through in one cycle, or performs a single
// data-memory load/store via valid/ready and returns the aligned result.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int WIDTH            = 32,
    parameter int REG_WIDTH        = 5,
    parameter int INSTR_TYPE_WIDTH = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [INSTR_TYPE_WIDTH-1:0] instr_type,
    input  logic [2:0]                  funct3,
    input  logic [WIDTH-1:0]            alu_result,
    input  logic [WIDTH-1:0]            rs2,
    input  logic [REG_WIDTH-1:0]        rd,
    input  logic                        rd_we,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_req_we,
    output logic [WIDTH-1:0]            mem_req_addr,
    output logic [WIDTH-1:0]            mem_req_wdata,
    output logic [3:0]                  mem_req_be,
    input  logic                        mem_rsp_valid,
    input  logic [WIDTH-1:0]            mem_rsp_rdata,
    output logic                        out_valid,
    output logic [REG_WIDTH-1:0]        out_rd,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_we,
    output logic                        out_fault
);

    lsu_state_e             state, state_next;
    logic                   is_store_r, rd_we_r;
    logic [2:0]             funct3_r;
    logic [WIDTH-1:0]       addr_r, rs2_r;
    logic [REG_WIDTH-1:0]   rd_r;

    logic                   accept, is_mem_in, in_idle, in_req;
    logic [2:0]             al_funct3;
    logic [1:0]             al_addr_lo;
    logic [3:0]             al_be;
    logic [WIDTH-1:0]       al_wdata, al_load;
    logic                   al_fault;

    logic                   out_valid_n, out_we_n, out_fault_n;
    logic [WIDTH-1:0]       out_data_n;
    logic [REG_WIDTH-1:0]   out_rd_n;

    assign in_idle   = (state == ST_IDLE);
    assign in_req    = (state == ST_REQ);
    assign in_ready  = in_idle && !reset;
    assign accept    = in_valid && in_ready;
    assign is_mem_in = (instr_type == IS_LOAD) || (instr_type == IS_STORE);

    // Fault check must see the live operands at acceptance; afterwards the
    // registered copies drive lanes and load alignment.
    assign al_funct3  = in_idle ? funct3 : funct3_r;
    assign al_addr_lo = in_idle ? alu_result[1:0] : addr_r[1:0];

    lsu_align #(.WIDTH(WIDTH)) u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .store_data (rs2_r),
        .load_word  (mem_rsp_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .fault      (al_fault)
    );

    assign mem_req_valid = in_req;
    assign mem_req_we    = in_req && is_store_r;
    assign mem_req_addr  = in_req ? {addr_r[WIDTH-1:2], 2'b00} : '0;
    assign mem_req_be    = in_req ? al_be : 4'b0000;
    assign mem_req_wdata = in_req ? al_wdata : '0;

    always_comb begin
        state_next  = state;
        out_valid_n = 1'b0;
        out_we_n    = 1'b0;
        out_fault_n = 1'b0;
        out_data_n  = out_data;
        out_rd_n    = out_rd;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!is_mem_in) begin
                        out_valid_n = 1'b1;
                        out_data_n  = alu_result;
                        out_rd_n    = rd;
                        out_we_n    = rd_we;
                    end else if (al_fault) begin
                        out_valid_n = 1'b1;
                        out_fault_n = 1'b1;
                        out_data_n  = '0;
                        out_rd_n    = rd;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_req_ready) begin
                    if (is_store_r) begin
                        out_valid_n = 1'b1;
                        out_data_n  = '0;
                        out_rd_n    = rd_r;
                        state_next  = ST_IDLE;
                    end else begin
                        state_next = ST_WAIT_RSP;
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    out_valid_n = 1'b1;
                    out_data_n  = al_load;
                    out_rd_n    = rd_r;
                    out_we_n    = rd_we_r;
                    state_next  = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            out_valid  <= 1'b0;
            out_we     <= 1'b0;
            out_fault  <= 1'b0;
            out_data   <= '0;
            out_rd     <= '0;
            is_store_r <= 1'b0;
            rd_we_r    <= 1'b0;
            funct3_r   <= 3'b000;
            addr_r     <= '0;
            rs2_r      <= '0;
            rd_r       <= '0;
        end else begin
            state     <= state_next;
            out_valid <= out_valid_n;
            out_we    <= out_we_n;
            out_fault <= out_fault_n;
            out_data  <= out_data_n;
            out_rd    <= out_rd_n;
            if (accept) begin
                is_store_r <= (instr_type == IS_STORE);
                rd_we_r    <= rd_we;
                funct3_r   <= funct3;
                addr_r     <= alu_result;
                rs2_r      <= rs2;
                rd_r       <= rd;
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, random transactions against
// an arithmetic reference model, and hand-written back-to-back / reset sequences.
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  instr_type = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] rs2 = '0;
    logic [4:0]  rd = '0;
    logic        rd_we = 1'b0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic        mem_req_we;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_be;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic [31:0] out_data;
    logic        out_we;
    logic        out_fault;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr_type(instr_type), .funct3(funct3), .alu_result(alu_result),
        .rs2(rs2), .rd(rd), .rd_we(rd_we),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .out_valid(out_valid), .out_rd(out_rd), .out_data(out_data),
        .out_we(out_we), .out_fault(out_fault)
    );

    typedef struct {
        logic [7:0]  itype;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic        rd_we;
        int          req_d;
        int          rsp_d;
        logic [31:0] rdata;
        logic        exp_req;
        logic        exp_we;
        logic        exp_fault;
        logic        chk_data;
        logic [31:0] exp_data;
        logic [31:0] exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_addr;
        int          exp_lat;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t stim(input logic [7:0] t, input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] s, input logic [4:0] r, input logic we,
                                  input int rqd, input int rsd, input logic [31:0] rdat);
        vec_t v;
        v = '{default: 0};
        v.itype = t; v.f3 = f; v.addr = a; v.rs2 = s; v.rd = r; v.rd_we = we;
        v.req_d = rqd; v.rsp_d = rsd; v.rdata = rdat; v.exp_lat = 1;
        return v;
    endfunction

    // Reference: size/lane arithmetic straight from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t   m;
        int     size, lane;
        longint val, sh, span;
        m = v;
        m.exp_req = 0; m.exp_we = 0; m.exp_fault = 0; m.chk_data = 0;
        m.exp_data = 0; m.exp_be = 0; m.exp_wdata = 0; m.exp_addr = 0; m.exp_lat = 1;
        if (v.itype != IS_LOAD && v.itype != IS_STORE) begin
            m.exp_data = v.addr; m.exp_we = v.rd_we; m.chk_data = 1;
            return m;
        end
        case (v.f3)
            3'd0, 3'd4: size = 1;
            3'd1, 3'd5: size = 2;
            3'd2:       size = 4;
            default:    size = 0;
        endcase
        lane = int'(v.addr % 4);
        if (size == 0 || (lane % size) != 0) begin
            m.exp_fault = 1;
            return m;
        end
        m.exp_req  = 1;
        m.exp_addr = v.addr - lane;
        m.exp_be   = ((1 << size) - 1) << lane;
        case (size)
            1:       m.exp_wdata = v.rs2[7:0] * 32'h01010101;
            2:       m.exp_wdata = v.rs2[15:0] * 32'h00010001;
            default: m.exp_wdata = v.rs2;
        endcase
        if (v.itype == IS_STORE) begin
            m.exp_lat = v.req_d + 2;
            return m;
        end
        if (size == 4) begin
            val = longint'(v.rdata);
        end else begin
            span = longint'(1) << (8 * size);
            sh   = longint'(v.rdata) >> (8 * lane);
            val  = sh % span;
            if (v.f3 < 3'd4 && val >= span / 2) val = val - span;
        end
        m.exp_data = val[31:0];
        m.exp_we   = v.rd_we;
        m.chk_data = 1;
        m.exp_lat  = v.req_d + v.rsp_d + 3;
        return m;
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        logic        got, seen_req, unstable, hs_next, bad_ready;
        logic [31:0] ra, rwd, od;
        logic [3:0]  rbe;
        logic        rwe, owe, oflt;
        logic [4:0]  ord;
        int          req_cnt, rsp_at, lat;
        got = 0; seen_req = 0; unstable = 0; hs_next = 0; bad_ready = 0;
        ra = 0; rwd = 0; rbe = 0; rwe = 0; od = 0; owe = 0; oflt = 0; ord = 0;
        req_cnt = 0; rsp_at = -1; lat = 0;
        @(negedge clk);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1; instr_type = v.itype; funct3 = v.f3; alu_result = v.addr;
        rs2 = v.rs2; rd = v.rd; rd_we = v.rd_we;
        for (int it = 1; it <= 40 && !got; it++) begin
            @(negedge clk);
            if (it == 1) begin
                in_valid = 0; instr_type = 8'($urandom); funct3 = 3'($urandom);
                alu_result = $urandom; rs2 = $urandom; rd = 5'($urandom); rd_we = 1'($urandom);
            end
            mem_rsp_valid = 0; mem_rsp_rdata = $urandom;
            if (hs_next) begin
                mem_req_ready = 0; hs_next = 0;
                if (v.itype == IS_LOAD) rsp_at = it + v.rsp_d;
            end
            if (out_valid) begin
                got = 1; lat = it; od = out_data; owe = out_we; oflt = out_fault; ord = out_rd;
            end else begin
                if (in_ready) bad_ready = 1;
                if (mem_req_valid) begin
                    if (!seen_req) begin
                        ra = mem_req_addr; rbe = mem_req_be; rwd = mem_req_wdata; rwe = mem_req_we;
                    end else if (ra !== mem_req_addr || rbe !== mem_req_be ||
                                 rwd !== mem_req_wdata || rwe !== mem_req_we) begin
                        unstable = 1;
                    end
                    seen_req = 1;
                    if (req_cnt == v.req_d) begin mem_req_ready = 1; hs_next = 1; end
                    req_cnt++;
                end
                if (it == rsp_at) begin mem_rsp_valid = 1; mem_rsp_rdata = v.rdata; end
            end
        end
        mem_req_ready = 0; mem_rsp_valid = 0;
        chk({tag, "_done"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({tag, "_fault"}, 32'(oflt), 32'(v.exp_fault));
        chk({tag, "_we"}, 32'(owe), 32'(v.exp_we));
        chk({tag, "_req_seen"}, 32'(seen_req), 32'(v.exp_req));
        if (v.chk_data) begin
            chk({tag, "_data"}, od, v.exp_data);
            chk({tag, "_rd"}, 32'(ord), 32'(v.rd));
        end
        if (v.exp_req) begin
            chk({tag, "_busy_ready"}, 32'(bad_ready), 32'd0);
            chk({tag, "_req_addr"}, ra, v.exp_addr);
            chk({tag, "_req_be"}, 32'(rbe), v.exp_be);
            chk({tag, "_req_we"}, 32'(rwe), 32'(v.itype == IS_STORE));
            chk({tag, "_req_stable"}, 32'(unstable), 32'd0);
            if (v.itype == IS_STORE) chk({tag, "_req_wdata"}, rwd, v.exp_wdata);
        end
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(out_valid), 32'd0);
    endtask

    vec_t tbl[$];
    vec_t v;

    initial begin
        // Directed table: expected values worked out by hand.
        v = stim(IS_ALU, 3'd0, 32'h5, 32'h0, 5'd3, 1'b1, 0, 0, 32'h0);
        v.exp_data = 32'h5; v.exp_we = 1; v.chk_data = 1; v.exp_lat = 1; tbl.push_back(v);
        v = stim(IS_STORE, F3_B, 32'h1003, 32'hAABBCCDD, 5'd0, 1'b0, 2, 0, 32'h0);
        v.exp_req = 1; v.exp_addr = 32'h1000; v.exp_be = 32'h8; v.exp_wdata = 32'hDDDDDDDD;
        v.exp_lat = 4; tbl.push_back(v);
        v = stim(IS_LOAD, F3_B, 32'h2001, 32'h0, 5'd7, 1'b1, 0, 0, 32'h123480FF);
        v.exp_req = 1; v.exp_addr = 32'h2000; v.exp_be = 32'h2; v.exp_we = 1; v.chk_data = 1;
        v.exp_data = 32'hFFFFFF80; v.exp_lat = 3; tbl.push_back(v);
        v = stim(IS_LOAD, F3_BU, 32'h2001, 32'h0, 5'd8, 1'b1, 1, 0, 32'h123480FF);
        v.exp_req = 1; v.exp_addr = 32'h2000; v.exp_be = 32'h2; v.exp_we = 1; v.chk_data = 1;
        v.exp_data = 32'h00000080; v.exp_lat = 4; tbl.push_back(v);
        v = stim(IS_LOAD, F3_H, 32'h2002, 32'h0, 5'd9, 1'b1, 0, 1, 32'h80010000);
        v.exp_req = 1; v.exp_addr = 32'h2000; v.exp_be = 32'hC; v.exp_we = 1; v.chk_data = 1;
        v.exp_data = 32'hFFFF8001; v.exp_lat = 4; tbl.push_back(v);
        v = stim(IS_LOAD, F3_HU, 32'h2002, 32'h0, 5'd10, 1'b1, 0, 2, 32'h80010000);
        v.exp_req = 1; v.exp_addr = 32'h2000; v.exp_be = 32'hC; v.exp_we = 1; v.chk_data = 1;
        v.exp_data = 32'h00008001; v.exp_lat = 5; tbl.push_back(v);
        v = stim(IS_LOAD, F3_W, 32'h2002, 32'h0, 5'd11, 1'b1, 0, 0, 32'h0);
        v.exp_fault = 1; v.exp_lat = 1; tbl.push_back(v);
        v = stim(IS_LOAD, 3'b011, 32'h2000, 32'h0, 5'd12, 1'b1, 0, 0, 32'h0);
        v.exp_fault = 1; v.exp_lat = 1; tbl.push_back(v);
        v = stim(IS_STORE, F3_H, 32'h1001, 32'h1234, 5'd0, 1'b0, 0, 0, 32'h0);
        v.exp_fault = 1; v.exp_lat = 1; tbl.push_back(v);
        v = stim(IS_STORE, F3_W, 32'h3000, 32'hCAFEBABE, 5'd0, 1'b0, 0, 0, 32'h0);
        v.exp_req = 1; v.exp_addr = 32'h3000; v.exp_be = 32'hF; v.exp_wdata = 32'hCAFEBABE;
        v.exp_lat = 2; tbl.push_back(v);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_we", 32'(out_we), 32'd0);
        chk("rst_out_fault", 32'(out_fault), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_req_addr", mem_req_addr, 32'd0);
        reset = 0;
        #1 chk("rst_release_ready", 32'(in_ready), 32'd1);

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back pass-through ops
        @(negedge clk);
        in_valid = 1; instr_type = IS_ALU; alu_result = 32'h5; rd = 5'd3; rd_we = 1;
        @(negedge clk);
        chk("b2b_ready", 32'(in_ready), 32'd1);
        chk("b2b_valid0", 32'(out_valid), 32'd1);
        chk("b2b_data0", out_data, 32'h5);
        instr_type = IS_BRANCH; alu_result = 32'h9; rd = 5'd4; rd_we = 0;
        @(negedge clk);
        in_valid = 0;
        chk("b2b_valid1", 32'(out_valid), 32'd1);
        chk("b2b_data1", out_data, 32'h9);
        chk("b2b_rd1", 32'(out_rd), 32'd4);
        chk("b2b_we1", 32'(out_we), 32'd0);
        @(negedge clk);
        chk("b2b_pulse", 32'(out_valid), 32'd0);

        // Reset while waiting for a slow load response
        in_valid = 1; instr_type = IS_LOAD; funct3 = F3_W; alu_result = 32'h4000; rd = 5'd2; rd_we = 1;
        @(negedge clk);
        in_valid = 0;
        chk("rmid_req_valid", 32'(mem_req_valid), 32'd1);
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        chk("rmid_wait_ready", 32'(in_ready), 32'd0);
        chk("rmid_wait_req", 32'(mem_req_valid), 32'd0);
        @(negedge clk);
        reset = 1;
        @(negedge clk);
        chk("rmid_req_dropped", 32'(mem_req_valid), 32'd0);
        chk("rmid_no_out", 32'(out_valid), 32'd0);
        reset = 0;
        #1 chk("rmid_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        mem_rsp_valid = 1; mem_rsp_rdata = 32'h55AA55AA;
        @(negedge clk);
        mem_rsp_valid = 0;
        chk("rmid_late_rsp", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("rmid_late_rsp2", 32'(out_valid), 32'd0);

        // Random transactions against the reference model
        for (int n = 0; n < 60; n++) begin
            logic [7:0] t;
            case ($urandom_range(0, 2))
                0:       t = ($urandom_range(0, 1) == 0) ? IS_ALU : IS_JUMP;
                1:       t = IS_LOAD;
                default: t = IS_STORE;
            endcase
            v = stim(t, 3'($urandom), $urandom, $urandom, 5'($urandom), 1'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
            if (n % 3 == 0) v.addr[1:0] = 2'b00;
            run_vec(model(v), $sformatf("rnd%0d", n));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1);
    end

endmodule
